// File: rtl/rr_arbiter_n.sv
// N-requester round-robin arbiter with a locked, registered one-hot grant and a rotating priority pointer.
// Optional hold-timeout rotation is compiled in with `define ARB_TIMEOUT_EN.
module rr_arbiter_n #(
  parameter int  NUM_REQ  = 3,
  parameter int  HOLD_MAX = 16,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               i_release,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               timeout,
  output logic               o_dbg_state
);

  // Handshake: a requester holds req[i] high until it sees grant[i]; while granted it
  // keeps req[i] high and ends ownership by pulsing i_release or by dropping req[i].

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_valid;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_ptr;

  logic [IDX_W-1:0]   w_next_ptr;
  logic [IDX_W-1:0]   w_search_ptr;
  logic [IDX_W-1:0]   w_win_idx;
  logic [NUM_REQ-1:0] w_win_oh;
  logic               w_found;
  logic               w_owner_req;
  logic               w_force;
  logic               w_end;
  logic               w_tmo_evt;
  int                 w_dist;
  int                 w_best;

  assign w_next_ptr   = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
  // On an end-of-ownership edge the search already starts past the old owner.
  assign w_search_ptr = (r_state == S_GRANT) ? w_next_ptr : r_ptr;
  assign w_owner_req  = |(req & r_grant);

  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_dist    = 0;
    w_best    = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - int'(w_search_ptr)) % NUM_REQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_win_idx = IDX_W'(i);
        w_found   = 1'b1;
      end
    end
  end

  always_comb begin
    w_win_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_oh[i] = w_found && (w_win_idx == IDX_W'(i));
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX);
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  assign w_force = (r_cnt == CNT_W'(HOLD_MAX - 1));
  assign timeout = r_timeout;
`else
  // No hold counter: the comparison is constant false for any legal HOLD_MAX.
  assign w_force = (HOLD_MAX < 0);
  assign timeout = 1'b0;
`endif

  assign w_end     = i_release | ~w_owner_req | w_force;
  assign w_tmo_evt = w_force & ~i_release & w_owner_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_grant <= w_win_oh;
            r_valid <= 1'b1;
            r_idx   <= w_win_idx;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (w_end) begin
            r_ptr   <= w_next_ptr;
            r_grant <= w_win_oh;
            r_valid <= w_found;
            r_idx   <= w_win_idx;
            r_state <= w_found ? S_GRANT : S_IDLE;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= w_tmo_evt;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            r_cnt <= r_cnt + CNT_W'(1);
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_idx   = r_idx;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed and randomized bench for rr_arbiter_n (NUM_REQ=3, HOLD_MAX=4) against a queue-free
// behavioural model: owner index, priority pointer and hold count tracked as plain integers.
module tb_rr_arbiter_n;

  localparam int N  = 3;
  localparam int HM = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         rel;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic         timeout;
  logic         dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_tmo;

  always #5 clk = ~clk;

  rr_arbiter_n #(.NUM_REQ(N), .HOLD_MAX(HM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .i_release   (rel),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout     (timeout),
    .o_dbg_state (dbg_state)
  );

  function automatic int pick(input logic [N-1:0] r, input int from);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (from + k) % N;
      if (((r >> idx) & 3'd1) != 3'd0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic rl);
    bit ab;
    bit forced;
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      if (r != '0) begin
        m_owner = pick(r, m_ptr);
        m_hold  = 0;
      end
    end else begin
      ab     = (((r >> m_owner) & 3'd1) == 3'd0);
      forced = TMO_EN && (m_hold == HM - 1);
      if (rl || ab || forced) begin
        m_tmo   = forced && !rl && !ab;
        m_ptr   = (m_owner + 1) % N;
        m_owner = pick(r, m_ptr);
        m_hold  = 0;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
    check({tag, ".idx"}, 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check({tag, ".timeout"}, 32'(timeout), 32'(m_tmo));
    check({tag, ".onehot"}, 32'($onehot0(grant)), 32'd1);
  endtask

  // Called at a falling edge: drive, advance the model, check #1 after the rising edge.
  task automatic tick(input string tag, input logic [N-1:0] r, input logic rl);
    req = r;
    rel = rl;
    model_step(r, rl);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 3'b111;
    rel   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    tick("first", 3'b111, 1'b0);
    for (int i = 0; i < 3; i++) tick("rotate", 3'b111, 1'b1);

    tick("skip", 3'b101, 1'b1);
    tick("wrap", 3'b101, 1'b1);

    for (int i = 0; i < 10; i++) tick("lock", 3'b011, 1'b0);
    tick("abandon", 3'b010, 1'b0);
    tick("hold1", 3'b110, 1'b0);

    async_reset("rst_mid");
    tick("after_rst", 3'b110, 1'b0);

    tick("to_idle", 3'b000, 1'b1);
    tick("idle", 3'b000, 1'b1);
    tick("tmo_start", 3'b011, 1'b0);
    for (int i = 0; i < 50; i++) tick("hold_tmo", 3'b011, 1'b0);
    tick("sole_rel", 3'b001, 1'b1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rand_rst");
      end else begin
        tick("rand", N'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
